frame_reorder_buffer: RTL and testbench

Parametrised double-buffered frame store that sits between the IFFT output stream and the DAC interface. It writes each incoming frame in bit-reversed (or natural) order into one bank while the other bank plays out sequentially at a decimated sample rate. Bank hand-off is gap-free. Overflow and underrun are reported explicitly. It generalises the fixed 1024-point, two-RAM bit-reverse/64x-hold path used in the vocoder datapath.

---
 rtl/frame_reorder_buffer.sv | 170 +++++++++++++++++
 tb/tb_frame_reorder_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reorder_buffer.sv
// Two-bank frame store: one bank is filled (bit-reversed or natural order) while
// the other bank plays out sequentially, one sample every 2^HOLD_LOG2 clocks.
module frame_reorder_buffer #(
    parameter int DATA_W    = 16,
    parameter int LOG2_N    = 10,
    parameter int HOLD_LOG2 = 6,
    parameter int BITREV    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_strobe,
    output logic              playing,
    output logic              underrun,
    output logic              overflow
);

    // state        | meaning
    // BANK_EMPTY   | bank free, may be (re)written by the input side
    // BANK_FULL    | complete frame waiting for its first playout tick
    // BANK_PLAYING | bank being read out, one word per tick

    localparam int N  = 1 << LOG2_N;
    localparam int PW = (HOLD_LOG2 > 0) ? HOLD_LOG2 : 1;
    localparam logic [LOG2_N-1:0] LAST = '1;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FULL    = 2'd1,
        BANK_PLAYING = 2'd2
    } bank_state_e;

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [LOG2_N-1:0] wcnt_q, wcnt_d;
    logic [LOG2_N-1:0] raddr_q, raddr_d;
    logic              overflow_q, overflow_d;
    logic [PW-1:0]     pcnt_q;
    logic              strobe_q;
    logic [DATA_W-1:0] out_data_q;

    logic              tick;
    logic              wr_en;
    logic              rd_en;
    logic              underrun_c;
    logic [LOG2_N-1:0] widx;
    logic [LOG2_N-1:0] waddr;
    logic [LOG2_N-1:0] rd_addr;

    logic [DATA_W-1:0] mem [2*N];

    function automatic logic [LOG2_N-1:0] bit_reverse(input logic [LOG2_N-1:0] a);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = a[LOG2_N-1-i];
        end
        return r;
    endfunction

    assign tick = (HOLD_LOG2 == 0) ? 1'b1 : (&pcnt_q);

    always_comb begin
        state_d    = state_q;
        wb_d       = wb_q;
        rb_d       = rb_q;
        wcnt_d     = wcnt_q;
        raddr_d    = raddr_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = raddr_q;
        underrun_c = 1'b0;
        widx       = in_sof ? '0 : wcnt_q;
        waddr      = (BITREV != 0) ? bit_reverse(widx) : widx;

        // A sof mid-frame simply restarts the same bank at index 0.
        if (in_valid) begin
            if (state_q[wb_q] != BANK_EMPTY) begin
                overflow_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (widx == LAST) begin
                    state_d[wb_q] = BANK_FULL;
                    wb_d          = ~wb_q;
                    wcnt_d        = '0;
                end else begin
                    wcnt_d = widx + 1'b1;
                end
            end
        end

        // Write only touches an EMPTY bank, read only a FULL/PLAYING one, so
        // the two updates never collide on the same bank.
        if (tick) begin
            case (state_q[rb_q])
                BANK_PLAYING: begin
                    rd_en = 1'b1;
                    if (raddr_q == LAST) begin
                        state_d[rb_q] = BANK_EMPTY;
                        rb_d          = ~rb_q;
                        raddr_d       = '0;
                    end else begin
                        raddr_d = raddr_q + 1'b1;
                    end
                end
                BANK_FULL: begin
                    state_d[rb_q] = BANK_PLAYING;
                    rd_en         = 1'b1;
                    rd_addr       = '0;
                    raddr_d       = LOG2_N'(1);
                end
                default: begin
                    underrun_c = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wcnt_q     <= '0;
            raddr_q    <= '0;
            overflow_q <= 1'b0;
            pcnt_q     <= '0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wcnt_q     <= wcnt_d;
            raddr_q    <= raddr_d;
            overflow_q <= overflow_d;
            pcnt_q     <= pcnt_q + 1'b1;
            strobe_q   <= tick;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wb_q, waddr}] <= in_data;
        end
    end

    // Registered read doubles as the output register; an underrun tick zeroes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q <= '0;
        end else if (rd_en) begin
            out_data_q <= mem[{rb_q, rd_addr}];
        end else if (tick) begin
            out_data_q <= '0;
        end
    end

    assign out_data   = out_data_q;
    assign out_strobe = strobe_q;
    assign playing    = (state_q[rb_q] == BANK_PLAYING);
    assign underrun   = underrun_c;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_frame_reorder_buffer.sv
// Bench for frame_reorder_buffer: two instances (N=16 bit-reversed with 4-clock
// hold, and N=16 natural order at full rate) checked against a frame-queue model.
module tb_frame_reorder_buffer;
    localparam int DW     = 16;
    localparam int LN     = 4;
    localparam int NN     = 16;
    localparam int HOLD_A = 2;
    localparam int HOLD_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         reset_s;
    logic [1:0]         valid_s;
    logic [1:0]         sof_s;
    logic [1:0][DW-1:0] data_s;
    logic [1:0][DW-1:0] odata;
    logic [1:0]         ostrobe;
    logic [1:0]         oplay;
    logic [1:0]         ounder;
    logic [1:0]         oover;

    frame_reorder_buffer #(.DATA_W(DW), .LOG2_N(LN), .HOLD_LOG2(HOLD_A), .BITREV(1)) dut_a (
        .clk(clk), .reset(reset_s[0]), .in_valid(valid_s[0]), .in_sof(sof_s[0]),
        .in_data(data_s[0]), .out_data(odata[0]), .out_strobe(ostrobe[0]),
        .playing(oplay[0]), .underrun(ounder[0]), .overflow(oover[0]));

    frame_reorder_buffer #(.DATA_W(DW), .LOG2_N(LN), .HOLD_LOG2(HOLD_B), .BITREV(0)) dut_b (
        .clk(clk), .reset(reset_s[1]), .in_valid(valid_s[1]), .in_sof(sof_s[1]),
        .in_data(data_s[1]), .out_data(odata[1]), .out_strobe(ostrobe[1]),
        .playing(oplay[1]), .underrun(ounder[1]), .overflow(oover[1]));

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int hold_l2 [2] = '{HOLD_A, HOLD_B};
    int rev_en  [2] = '{1, 0};
    int exp_br  [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    // Model: a partial-frame buffer, a queue of playout-ordered samples of every
    // held (complete, not yet fully played) frame, and a free-running pace count.
    logic [DW-1:0] m_part [2][NN];
    logic [DW-1:0] m_q0[$];
    logic [DW-1:0] m_q1[$];
    int            m_wcnt [2];
    int            m_held [2];
    bit            m_play [2];
    int            m_pos  [2];
    int            m_pace [2];
    bit            m_over [2];
    bit            m_strb [2];
    logic [DW-1:0] m_out  [2];

    logic [DW-1:0] cap_a[$];
    logic [DW-1:0] cap_b[$];
    int            t_a[$];
    bit            prev_ur [2];
    int            gap_a = 0;

    task automatic check(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d) at cycle %0d: actual %0d required %0d", nm, u, cyc, act, exp);
        end
    endtask

    function automatic int rev_idx(input int k);
        int r = 0;
        for (int i = 0; i < LN; i++) if (((k >> i) & 1) != 0) r |= 1 << (LN - 1 - i);
        return r;
    endfunction

    task automatic model_step(input int u);
        int held0;
        bit tk;
        int idx;
        logic [DW-1:0] v;
        if (reset_s[u]) begin
            m_wcnt[u] = 0; m_held[u] = 0; m_play[u] = 0; m_pos[u] = 0;
            m_pace[u] = 0; m_over[u] = 0; m_strb[u] = 0; m_out[u] = '0;
            if (u == 0) m_q0.delete(); else m_q1.delete();
            return;
        end
        held0 = m_held[u];
        tk = (m_pace[u] == (1 << hold_l2[u]) - 1);
        m_strb[u] = tk;
        if (tk) begin
            if (m_play[u] || held0 > 0) begin
                if (!m_play[u]) begin
                    m_play[u] = 1;
                    m_pos[u]  = 0;
                end
                if (u == 0) v = m_q0.pop_front(); else v = m_q1.pop_front();
                m_out[u] = v;
                m_pos[u]++;
                if (m_pos[u] == NN) begin
                    m_play[u] = 0;
                    m_pos[u]  = 0;
                    m_held[u]--;
                end
            end else begin
                m_out[u] = '0;
            end
        end
        if (valid_s[u]) begin
            if (held0 >= 2) begin
                m_over[u] = 1;
            end else begin
                idx = sof_s[u] ? 0 : m_wcnt[u];
                m_part[u][idx] = data_s[u];
                if (idx == NN - 1) begin
                    for (int k = 0; k < NN; k++) begin
                        v = m_part[u][(rev_en[u] != 0) ? rev_idx(k) : k];
                        if (u == 0) m_q0.push_back(v); else m_q1.push_back(v);
                    end
                    m_held[u]++;
                    m_wcnt[u] = 0;
                end else begin
                    m_wcnt[u] = idx + 1;
                end
            end
        end
        m_pace[u] = (m_pace[u] + 1) % (1 << hold_l2[u]);
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) model_step(u);
    end

    always @(negedge clk) begin
        bit exp_ur;
        for (int u = 0; u < 2; u++) begin
            exp_ur = (m_pace[u] == (1 << hold_l2[u]) - 1) && !m_play[u] && (m_held[u] == 0);
            check("out_strobe", u, ostrobe[u], m_strb[u]);
            check("out_data",   u, odata[u],   m_out[u]);
            check("playing",    u, oplay[u],   m_play[u]);
            check("underrun",   u, ounder[u],  exp_ur);
            check("overflow",   u, oover[u],   m_over[u]);
            if (ostrobe[u] && !prev_ur[u]) begin
                if (u == 0) begin
                    cap_a.push_back(odata[0]);
                    t_a.push_back(cyc);
                end else begin
                    cap_b.push_back(odata[1]);
                end
            end
            prev_ur[u] = ounder[u];
        end
        if (ounder[0] && cap_a.size() >= 1 && cap_a.size() < 32) gap_a++;
    end

    task automatic send_frame(input logic [1:0] mask, input int base, input int len);
        for (int k = 0; k < len; k++) begin
            valid_s   = mask;
            sof_s     = (k == 0) ? mask : 2'b00;
            data_s[0] = DW'(base + k);
            data_s[1] = DW'(base + k);
            @(negedge clk);
        end
        valid_s = '0;
        sof_s   = '0;
    endtask

    initial begin
        int ur_a, ur_b, bad, size_b;
        reset_s = 2'b11;
        valid_s = '0;
        sof_s   = '0;
        data_s  = '0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset out_data",   u, odata[u],   0);
            check("reset out_strobe", u, ostrobe[u], 0);
            check("reset playing",    u, oplay[u],   0);
            check("reset overflow",   u, oover[u],   0);
        end
        reset_s = 2'b00;

        ur_a = 0; ur_b = 0;
        repeat (12) begin
            @(negedge clk);
            ur_a += int'(ounder[0]);
            ur_b += int'(ounder[1]);
        end
        check("idle underruns", 0, ur_a, 3);
        check("idle underruns", 1, ur_b, 12);

        send_frame(2'b11, 0, 16);
        send_frame(2'b11, 100, 16);
        send_frame(2'b11, 200, 16);
        @(negedge clk);
        check("overflow after third frame", 0, oover[0], 1);
        check("no overflow at full rate",   1, oover[1], 0);

        repeat (150) @(negedge clk);
        check("frames 1-2 sample count", 0, cap_a.size(), 32);
        if (cap_a.size() >= 32) begin
            for (int k = 0; k < 16; k++) begin
                check("frame1 bitrev order", 0, cap_a[k],      exp_br[k]);
                check("frame2 bitrev order", 0, cap_a[16 + k], 100 + exp_br[k]);
            end
            bad = 0;
            for (int k = 0; k < 31; k++) if (t_a[k + 1] - t_a[k] != 4) bad++;
            check("strobe spacing of 4", 0, bad, 0);
        end
        check("underruns between frames", 0, gap_a, 0);
        check("overflow stays set", 0, oover[0], 1);
        check("three frames sample count", 1, cap_b.size(), 48);
        if (cap_b.size() >= 48) begin
            bad = 0;
            for (int k = 0; k < 16; k++) begin
                if (cap_b[k] != DW'(k)) bad++;
                if (cap_b[16 + k] != DW'(100 + k)) bad++;
                if (cap_b[32 + k] != DW'(200 + k)) bad++;
            end
            check("natural order frames", 1, bad, 0);
        end

        send_frame(2'b11, 300, 5);
        send_frame(2'b11, 400, 16);
        repeat (100) @(negedge clk);
        check("sof restart sample count", 0, cap_a.size(), 48);
        if (cap_a.size() >= 48)
            for (int k = 0; k < 16; k++)
                check("sof restart frame", 0, cap_a[32 + k], 400 + exp_br[k]);
        check("sof restart sample count", 1, cap_b.size(), 64);
        if (cap_b.size() >= 64) begin
            bad = 0;
            for (int k = 0; k < 16; k++) if (cap_b[48 + k] != DW'(400 + k)) bad++;
            check("sof restart frame", 1, bad, 0);
        end

        send_frame(2'b11, 500, 16);
        repeat (4) @(negedge clk);
        check("playing before reset", 1, oplay[1], 1);
        reset_s[1] = 1'b1;
        @(negedge clk);
        reset_s[1] = 1'b0;
        check("mid-play reset out_data",   1, odata[1],   0);
        check("mid-play reset out_strobe", 1, ostrobe[1], 0);
        check("mid-play reset playing",    1, oplay[1],   0);
        check("mid-play reset overflow",   1, oover[1],   0);
        size_b = cap_b.size();
        ur_b = 0;
        repeat (20) begin
            @(negedge clk);
            ur_b += int'(ounder[1]);
        end
        check("underruns after reset", 1, ur_b, 20);
        check("no samples after reset", 1, cap_b.size(), size_b);

        send_frame(2'b10, 600, 16);
        repeat (30) @(negedge clk);
        check("new frame after reset count", 1, cap_b.size(), size_b + 16);
        if (cap_b.size() >= size_b + 16) begin
            bad = 0;
            for (int k = 0; k < 16; k++) if (cap_b[size_b + k] != DW'(600 + k)) bad++;
            check("new frame after reset data", 1, bad, 0);
        end

        repeat (20) @(negedge clk);
        check("frame 500 sample count", 0, cap_a.size(), 64);
        if (cap_a.size() >= 64)
            for (int k = 0; k < 16; k++)
                check("frame 500 bitrev order", 0, cap_a[48 + k], 500 + exp_br[k]);
        check("overflow sticky at end", 0, oover[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
